// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC sequencer.
// Reset/exception vector defaults and the redirect-source encoding.
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

    typedef enum logic [1:0] {
        SRC_EXC  = 2'd0,
        SRC_ERET = 2'd1,
        SRC_BR   = 2'd2,
        SRC_JMP  = 2'd3
    } src_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer.
// Keeps a redirect seen during a stall until fetch can take it.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             clear,
    input  logic [WIDTH-1:0] target_in,
    output logic             valid,
    output logic [WIDTH-1:0] target
);

    // Clear wins; a capture overwrites any older entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (capture) begin
            valid  <= 1'b1;
            target <= target_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Priority redirect select, next-PC mux and the PC register.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(EXC_VEC_DEF),
    parameter int               INC        = 4,
    parameter int               ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_req,
    input  logic [WIDTH-1:0] jmp_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pend_valid,
    output logic             misalign
);

    src_e             sel_src;
    logic [WIDTH-1:0] sel_tgt;
    logic             any_req;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] pc_next;
    logic             buf_capture;
    logic             buf_clear;

    assign any_req  = eret_req | br_taken | jmp_req;
    assign pc_plus  = pc + WIDTH'(INC);
    assign misalign = |pc[ALIGN_BITS-1:0];

    // Highest-priority request and its target.
    always_comb begin
        sel_src = SRC_JMP;
        if (exc_req)       sel_src = SRC_EXC;
        else if (eret_req) sel_src = SRC_ERET;
        else if (br_taken) sel_src = SRC_BR;
        case (sel_src)
            SRC_EXC:  sel_tgt = EXC_VEC;
            SRC_ERET: sel_tgt = epc;
            SRC_BR:   sel_tgt = br_target;
            default:  sel_tgt = jmp_target;
        endcase
    end

    // Next-PC selection and pending-buffer control.
    always_comb begin
        pc_next     = pc_plus;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        if (exc_req) begin
            pc_next   = EXC_VEC;
            buf_clear = 1'b1;
        end else if (stall) begin
            pc_next     = pc;
            buf_capture = any_req;
        end else if (any_req) begin
            pc_next   = sel_tgt;
            buf_clear = 1'b1;
        end else if (pend_valid) begin
            pc_next   = pend_target;
            buf_clear = 1'b1;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_VEC;
        else        pc <= pc_next;
    end

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (buf_capture),
        .clear     (buf_clear),
        .target_in (sel_tgt),
        .valid     (pend_valid),
        .target    (pend_target)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
// Each task drives one scenario and checks pc/pend_valid inline.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_req;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pend_valid;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .pc         (pc),
        .pc_plus    (pc_plus),
        .pend_valid (pend_valid),
        .misalign   (misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold pc=%h pv=%b want 3000/0", pc, pend_valid);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (pc !== 32'h3000) begin
            errors++;
            $display("FAIL rst_rel pc=%h want 3000", pc);
        end
        step();
        checks++;
        if (pc !== 32'h3004 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq1 pc=%h pv=%b want 3004/0", pc, pend_valid);
        end
        step();
        checks++;
        if (pc !== 32'h3008 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq2 pc=%h pv=%b want 3008/0", pc, pend_valid);
        end
        repeat (2) step();
        checks++;
        if (pc !== 32'h3010 || pc_plus !== 32'h3014) begin
            errors++;
            $display("FAIL seq3 pc=%h plus=%h want 3010/3014", pc, pc_plus);
        end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h3400;
        step();
        br_taken = 1'b0;
        checks++;
        if (pc !== 32'h3010 || pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_cap pc=%h pv=%b want 3010/1", pc, pend_valid);
        end
        step();
        checks++;
        if (pc !== 32'h3010 || pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_hold pc=%h pv=%b want 3010/1", pc, pend_valid);
        end
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'h3400 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL br_apply pc=%h pv=%b want 3400/0", pc, pend_valid);
        end
        step();
        checks++;
        if (pc !== 32'h3404) begin
            errors++;
            $display("FAIL br_next pc=%h want 3404", pc);
        end
    endtask

    task automatic test_exc_priority();
        stall = 1'b1;
        exc_req = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h3500;
        jmp_req = 1'b1;
        jmp_target = 32'h3600;
        step();
        checks++;
        if (pc !== 32'h4180 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL exc pc=%h pv=%b want 4180/0", pc, pend_valid);
        end
        stall = 1'b0;
        exc_req = 1'b0;
        jmp_req = 1'b0;
        eret_req = 1'b1;
        epc = 32'h3020;
        step();
        eret_req = 1'b0;
        br_taken = 1'b0;
        checks++;
        if (pc !== 32'h3020 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL eret pc=%h pv=%b want 3020/0", pc, pend_valid);
        end
    endtask

    task automatic test_live_beats_pending();
        stall = 1'b1;
        jmp_req = 1'b1;
        jmp_target = 32'h3800;
        step();
        jmp_req = 1'b0;
        checks++;
        if (pc !== 32'h3020 || pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL jmp_cap pc=%h pv=%b want 3020/1", pc, pend_valid);
        end
        stall = 1'b0;
        br_taken = 1'b1;
        br_target = 32'h3C00;
        step();
        br_taken = 1'b0;
        checks++;
        if (pc !== 32'h3C00 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL live pc=%h pv=%b want 3C00/0", pc, pend_valid);
        end
        step();
        checks++;
        if (pc !== 32'h3C04) begin
            errors++;
            $display("FAIL discard pc=%h want 3C04", pc);
        end
    endtask

    task automatic test_wrap_misalign();
        jmp_req = 1'b1;
        jmp_target = 32'hFFFF_FFFC;
        step();
        jmp_req = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0) begin
            errors++;
            $display("FAIL top pc=%h plus=%h want FFFFFFFC/0", pc, pc_plus);
        end
        step();
        checks++;
        if (pc !== 32'h0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL wrap pc=%h mis=%b want 0/0", pc, misalign);
        end
        jmp_req = 1'b1;
        jmp_target = 32'h3002;
        step();
        jmp_req = 1'b0;
        checks++;
        if (pc !== 32'h3002 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL mis pc=%h mis=%b want 3002/1", pc, misalign);
        end
        checks++;
        if (pc_plus !== 32'h3006) begin
            errors++;
            $display("FAIL mis_plus plus=%h want 3006", pc_plus);
        end
    endtask

    task automatic test_reset_pending();
        stall = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h3400;
        step();
        br_taken = 1'b0;
        checks++;
        if (pend_valid !== 1'b1 || pc !== 32'h3002) begin
            errors++;
            $display("FAIL rp_cap pc=%h pv=%b want 3002/1", pc, pend_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL rp_async pc=%h pv=%b want 3000/0", pc, pend_valid);
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL rp_stall pc=%h pv=%b want 3000/0", pc, pend_valid);
        end
        stall = 1'b0;
        step();
        checks++;
        if (pc !== 32'h3004 || pend_valid !== 1'b0) begin
            errors++;
            $display("FAIL rp_seq pc=%h pv=%b want 3004/0", pc, pend_valid);
        end
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        exc_req = 1'b0;
        eret_req = 1'b0;
        epc = '0;
        br_taken = 1'b0;
        br_target = '0;
        jmp_req = 1'b0;
        jmp_target = '0;
        #1;
        test_reset();
        test_branch_stall();
        test_exc_priority();
        test_live_beats_pending();
        test_wrap_misalign();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. Holds the current PC and selects the next PC each cycle from sequential increment, jump, branch, exception-return and exception-vector sources. A one-entry pending-redirect buffer keeps any redirect that arrives while fetch is stalled, so no control transfer is lost. Its output feeds instruction-memory addressing and the IF/ID pipeline register.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VEC, 32'h0000_3000: PC value loaded at reset.
- EXC_VEC, 32'h0000_4180: exception handler entry.
- INC, 4: sequential increment.
- ALIGN_BITS, 2: low PC bits that must be zero.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low. The block is in reset while this is 0.
- stall  in  1  hold PC. It does not block exceptions.
- exc_req  in  1  exception: redirect to EXC_VEC.
- eret_req  in  1  exception return: redirect to epc.
- epc  in  WIDTH  return address.
- br_taken  in  1  taken branch: redirect to br_target.
- br_target  in  WIDTH  branch target.
- jmp_req  in  1  jump: redirect to jmp_target.
- jmp_target  in  WIDTH  jump target.
- pc  out  WIDTH  current PC (registered).
- pc_plus  out  WIDTH  pc + INC (combinational, modulo 2^WIDTH).
- pend_valid  out  1  a redirect is buffered (registered).
- misalign  out  1  pc[ALIGN_BITS-1:0] != 0 (combinational).

## Operation
- Redirect priority is exc_req > eret_req > br_taken > jmp_req. The request with the highest priority is "sel_req", and its target is "sel_tgt".
- Each rising clk edge applies the first matching rule below:
  1. exc_req: pc <= EXC_VEC. pend_valid <= 0. This applies even when stall is 1.
  2. stall and any of eret_req, br_taken or jmp_req: pc holds. pend_target <= sel_tgt and pend_valid <= 1. A new request overwrites an existing pending entry.
  3. stall with no request: pc, pend_valid and pend_target all hold.
  4. no stall and any request: pc <= sel_tgt. pend_valid <= 0. A live request beats the pending entry, which is discarded.
  5. no stall, no request, pend_valid: pc <= pend_target. pend_valid <= 0.
  6. otherwise: pc <= pc + INC.
- All arithmetic is unsigned and modulo 2^WIDTH. Incrementing WIDTH'hFFFF_FFFC by 4 wraps to 0.
- Misaligned targets are loaded unchanged. misalign only flags them; trap generation happens downstream.
- While reset is 0: pc = RESET_VEC, pend_valid = 0, pend_target = 0. This holds from assertion, independent of clk.

## Timing
- Redirect latency is one cycle: a request sampled at edge N appears on pc after edge N.
- A redirect buffered during a stall appears on pc one edge after stall deasserts (rule 5).
- pc_plus and misalign follow pc combinationally in the same cycle.
- Reset asserted mid-stall with pend_valid=1 drops the pending redirect. After release, the first edge with stall=0 gives pc = RESET_VEC + INC.
- Reset deassertion is asynchronous to clk, and the block has no internal synchroniser. Reset must be released synchronously upstream.
- A request held for several stalled cycles is simply re-captured each cycle, so no duplicate action occurs.

## Structure
- Shared package pc_pkg holds:
  - the RESET_VEC and EXC_VEC defaults;
  - the 2-bit redirect-source enum (SRC_EXC, SRC_ERET, SRC_BR, SRC_JMP), used by the priority select and by trace/debug.
- One natural sub-module, pc_redirect_buf: the one-entry pending buffer (valid, target, capture/clear). This keeps the top level to priority select, next-PC mux and the PC register.
- There are no other sub-modules. The PC register lives in pc_sequencer.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release with no requests → pc=0x3000, then 0x3004 and 0x3008, pend_valid=0 throughout.
- Branch under stall: stall=1 at pc=0x3010 and pulse br_taken with br_target=0x3400 for one cycle → pc stays 0x3010, pend_valid=1. Release stall → next pc=0x3400, pend_valid=0, then 0x3404.
- Exception beats stall and priority: stall=1 with exc_req, br_taken and jmp_req all asserted → pc=0x4180, pend_valid=0. Then eret_req+br_taken with epc=0x3020, no stall → pc=0x3020.
- Live request beats pending: with a pending jump to 0x3800, release stall while br_taken=1 and br_target=0x3C00 → pc=0x3C00, and the pending entry is discarded.
- Wrap and misalign: jmp_target=0xFFFF_FFFC, then a free-running cycle → pc=0x0000_0000. jmp_target=0x3002 → pc=0x3002, misalign=1.
- Reset mid-pending: pend_valid=1 with target 0x3400, then assert reset asynchronously between edges → pc=0x3000 and pend_valid=0 immediately. After release the sequence runs 0x3004, not 0x3400.
